// File: rtl/serial_subtractor_4b_if.sv
// serial_subtractor_4b_if
//   Request/result bundle for the bit-serial subtractor.
//   master: drives start, A, B, Bin; observes busy, done, D, Bout (and V).
//   slave : the subtractor side.
//   V exists only when SUB_OVF_FLAG_EN is defined.
interface serial_subtractor_4b_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SUB_OVF_FLAG_EN
  logic             V;
`endif

  modport master (
    output start, A, B, Bin,
`ifdef SUB_OVF_FLAG_EN
    input  V,
`endif
    input  busy, done, D, Bout
  );

  modport slave (
    input  start, A, B, Bin,
`ifdef SUB_OVF_FLAG_EN
    output V,
`endif
    output busy, done, D, Bout
  );
endinterface

// File: rtl/serial_subtractor_4b.sv
// serial_subtractor_4b
//   Bit-serial A - B - Bin: one full-subtractor cell plus a borrow flop,
//   iterated LSB first over WIDTH clocks.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - serial_subtractor_4b_if.slave (start/A/B/Bin in,
//            busy/done/D/Bout[/V] out)
//   Optional feature macro: SUB_OVF_FLAG_EN adds the signed-overflow flag V.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | processing one bit per clock (busy)
//   DONE  | one-cycle done pulse; accepts a back-to-back start
module serial_subtractor_4b #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  serial_subtractor_4b_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_full;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             load, last_bit;
  logic             a0, b0, d_bit, br_nx;
  logic             busy_c, done_c;

  assign load     = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  assign a0       = a_sr[0];
  assign b0       = b_sr[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_nx    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  // Completed result as it will look after this bit is shifted in.
  assign res_full = {d_bit, res_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      SHIFT:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      res_sr <= '0;
      br_q   <= bus.Bin;
      cnt_q  <= '0;
    end else if (state_q == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_full[WIDTH-1:1];
      br_q   <= br_nx;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Results are captured on the edge that enters DONE so they are
  // already valid while done is high, and held until the next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (last_bit) begin
      d_q    <= res_full;
      bout_q <= br_nx;
    end
  end

`ifdef SUB_OVF_FLAG_EN
  // Operand sign bits {A msb, B msb} kept for the overflow flag.
  logic [1:0] sgn_q;
  logic       v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_q <= 2'b00;
      v_q   <= 1'b0;
    end else begin
      if (load) sgn_q <= {bus.A[WIDTH-1], bus.B[WIDTH-1]};
      if (last_bit) v_q <= (sgn_q[1] ^ sgn_q[0]) & (d_bit ^ sgn_q[1]);
    end
  end

  assign bus.V = v_q;
`endif
endmodule
